// File: rtl/sa_skew_feeder.sv
// rtl/sa_skew_feeder.sv - skewed operand feeder for the N x N output-stationary systolic array
// Buffers one K-deep A/B operand set, then replays it diagonally skewed with the array enable.
module sa_skew_feeder #(
  parameter int WIDTH = 8,
  parameter int N     = 2,
  parameter int K     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0][WIDTH-1:0]   a_col,
  input  logic [N-1:0][WIDTH-1:0]   b_row,
  output logic                      sa_en,
  output logic [N-1:0][WIDTH-1:0]   a_out,
  output logic [N-1:0][WIDTH-1:0]   b_out,
  output logic                      busy,
  output logic                      done
);

  localparam int S  = K + 2 * N - 2;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int SW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                          state, nxt_state;
  logic [KW-1:0]                   k_cnt, nxt_k;
  logic [SW-1:0]                   s_cnt, nxt_s;
  logic [K-1:0][N-1:0][WIDTH-1:0]  a_buf, b_buf, a_buf_n, b_buf_n;
  logic [N-1:0][WIDTH-1:0]         a_nxt, b_nxt;
  int                              d;

  always_comb begin
    nxt_state = state;
    nxt_k     = k_cnt;
    nxt_s     = s_cnt;
    a_buf_n   = a_buf;
    b_buf_n   = b_buf;
    case (state)
      ST_LOAD: begin
        if (in_valid) begin
          a_buf_n[k_cnt] = a_col;
          b_buf_n[k_cnt] = b_row;
          if (k_cnt == KW'(K - 1)) begin
            nxt_k     = '0;
            nxt_s     = '0;
            nxt_state = ST_STREAM;
          end else begin
            nxt_k = k_cnt + KW'(1);
          end
        end
      end
      ST_STREAM: begin
        if (s_cnt == SW'(S - 1)) begin
          nxt_s     = '0;
          nxt_state = ST_DONE;
        end else begin
          nxt_s = s_cnt + SW'(1);
        end
      end
      ST_DONE: nxt_state = ST_LOAD;
      default: nxt_state = ST_LOAD;
    endcase
  end

  // Outputs are precomputed for the coming cycle; the buffer view includes a beat written this edge.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    d     = 0;
    if (nxt_state == ST_STREAM) begin
      for (int i = 0; i < N; i++) begin
        d = int'(nxt_s) - i;
        if (d >= 0 && d < K) begin
          a_nxt[i] = a_buf_n[d[KW-1:0]][i];
          b_nxt[i] = b_buf_n[d[KW-1:0]][i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_LOAD;
      k_cnt    <= '0;
      s_cnt    <= '0;
      in_ready <= 1'b1;
      sa_en    <= 1'b0;
      a_out    <= '0;
      b_out    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt_state;
      k_cnt    <= nxt_k;
      s_cnt    <= nxt_s;
      in_ready <= (nxt_state == ST_LOAD);
      sa_en    <= (nxt_state == ST_STREAM);
      a_out    <= a_nxt;
      b_out    <= b_nxt;
      busy     <= (nxt_state != ST_LOAD);
      done     <= (nxt_state == ST_DONE);
    end
  end

  // Operand storage needs no reset: it is always fully rewritten before being streamed.
  always_ff @(posedge clk) begin
    a_buf <= a_buf_n;
    b_buf <= b_buf_n;
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb/tb_sa_skew_feeder.sv - self-checking bench for sa_skew_feeder
// Checks streams against the skew formula and array results against a plain matrix product.
module tb_sa_skew_feeder;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int K  = 2;
  localparam int S  = K + 2 * N - 2;
  localparam int N3 = 3;
  localparam int K3 = 1;
  localparam int S3 = K3 + 2 * N3 - 2;

  typedef logic [N-1:0][W-1:0]  vecn_t;
  typedef logic [N3-1:0][W-1:0] vec3_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid, in_ready, sa_en, busy, done;
  vecn_t a_col, b_row, a_out, b_out;
  logic  in_valid3, in_ready3, sa_en3, busy3, done3;
  vec3_t a_col3, b_row3, a_out3, b_out3;

  sa_skew_feeder #(.WIDTH(W), .N(N), .K(K)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .sa_en(sa_en), .a_out(a_out), .b_out(b_out),
    .busy(busy), .done(done)
  );

  sa_skew_feeder #(.WIDTH(W), .N(N3), .K(K3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .a_col(a_col3), .b_row(b_row3), .sa_en(sa_en3), .a_out(a_out3), .b_out(b_out3),
    .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_done_cyc = 0;

  int    A [N][K];
  int    B [K][N];
  vecn_t ha [S];
  vecn_t hb [S];
  vec3_t h3a [S3];
  vec3_t h3b [S3];

  typedef struct {
    logic  vld;
    vecn_t a;
    vecn_t b;
    logic  rdy;
    logic  en;
    logic  bsy;
    logic  dn;
    vecn_t ea;
    vecn_t eb;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vecn_t pk(input int x0, input int x1);
    vecn_t r;
    r[0] = W'(x0);
    r[1] = W'(x1);
    return r;
  endfunction

  // What cell (i,j) of an output-stationary array accumulates from the recorded streams.
  function automatic int acc_of(input int i, input int j);
    int acc = 0;
    for (int t = 0; t < S; t++)
      if (t - j >= 0 && t - i >= 0)
        acc = acc + $signed(ha[t-j][i]) * $signed(hb[t-i][j]);
    return acc;
  endfunction

  function automatic int cref(input int i, input int j);
    int c = 0;
    for (int k = 0; k < K; k++) c = c + A[i][k] * B[k][j];
    return c;
  endfunction

  // mode 0: valid held high, 1: random valid, 2: valid toggled 1,0,1...
  task automatic run_set(input int mode, input int abort_at, input bit hold, input bit b2b);
    int    got = 0;
    int    guard = 0;
    vecn_t ea, eb;
    while (got < K && guard < 100) begin
      @(negedge clk);
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = 1'($urandom_range(0, 1));
        default: in_valid = (guard % 2 == 0);
      endcase
      for (int i = 0; i < N; i++) begin
        a_col[i] = in_valid ? W'(A[i][got]) : W'($urandom);
        b_row[i] = in_valid ? W'(B[got][i]) : W'($urandom);
      end
      if (in_valid && in_ready) got++;
      guard++;
    end
    if (got < K) begin
      check("load_timeout", 64'(got), 64'(K));
      return;
    end
    for (int t = 0; t < S; t++) begin
      @(negedge clk);
      if (b2b && t == 0) check("b2b_gap", 64'(cyc - last_done_cyc), 64'(K + 1));
      for (int i = 0; i < N; i++) begin
        ea[i] = (t - i >= 0 && t - i < K) ? W'(A[i][t-i]) : '0;
        eb[i] = (t - i >= 0 && t - i < K) ? W'(B[t-i][i]) : '0;
      end
      check($sformatf("stream_t%0d", t), {in_ready, sa_en, busy, done, a_out, b_out},
            {4'b0110, ea, eb});
      ha[t] = a_out;
      hb[t] = b_out;
      in_valid = 1'($urandom_range(0, 1));
      a_col    = vecn_t'($urandom);
      b_row    = vecn_t'($urandom);
      if (t == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check("async_rst", {in_ready, sa_en, busy, done, a_out, b_out}, {4'b1000, 32'b0});
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("rst_no_done", {sa_en, done}, 2'b00);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {in_ready, busy, done}, 3'b100);
        return;
      end
    end
    @(negedge clk);
    check("done_cycle", {in_ready, sa_en, busy, done, a_out, b_out}, {4'b0011, 32'b0});
    last_done_cyc = cyc;
    in_valid = hold;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("acc_%0d%0d", i, j), 64'(acc_of(i, j)), 64'(cref(i, j)));
  endtask

  task automatic set_ab(input int a00, input int a01, input int a10, input int a11,
                        input int b00, input int b01, input int b10, input int b11);
    A[0][0] = a00; A[0][1] = a01; A[1][0] = a10; A[1][1] = a11;
    B[0][0] = b00; B[0][1] = b01; B[1][0] = b10; B[1][1] = b11;
  endtask

  task automatic set_rand();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        A[i][k] = int'($urandom_range(0, 255)) - 128;
        B[k][i] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sidx;
    int acc;
    vec3_t e3a, e3b;
    int exp_c [2][2];

    tbl[0] = '{1'b1, pk(1, 3), pk(5, 6), 1'b1, 1'b0, 1'b0, 1'b0, pk(0, 0), pk(0, 0)};
    tbl[1] = '{1'b1, pk(2, 4), pk(7, 8), 1'b1, 1'b0, 1'b0, 1'b0, pk(0, 0), pk(0, 0)};
    tbl[2] = '{1'b1, pk(9, 9), pk(9, 9), 1'b0, 1'b1, 1'b1, 1'b0, pk(1, 0), pk(5, 0)};
    tbl[3] = '{1'b1, pk(11, 12), pk(13, 14), 1'b0, 1'b1, 1'b1, 1'b0, pk(2, 3), pk(7, 6)};
    tbl[4] = '{1'b1, pk(15, 16), pk(17, 18), 1'b0, 1'b1, 1'b1, 1'b0, pk(0, 4), pk(0, 8)};
    tbl[5] = '{1'b1, pk(19, 20), pk(21, 22), 1'b0, 1'b1, 1'b1, 1'b0, pk(0, 0), pk(0, 0)};
    tbl[6] = '{1'b0, pk(0, 0), pk(0, 0), 1'b0, 1'b0, 1'b1, 1'b1, pk(0, 0), pk(0, 0)};
    tbl[7] = '{1'b0, pk(0, 0), pk(0, 0), 1'b1, 1'b0, 1'b0, 1'b0, pk(0, 0), pk(0, 0)};
    exp_c = '{'{19, 22}, '{43, 50}};

    rst_n = 1'b0;
    in_valid = 1'b0; a_col = '0; b_row = '0;
    in_valid3 = 1'b0; a_col3 = '0; b_row3 = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {in_ready, sa_en, busy, done, a_out, b_out}, {4'b1000, 32'b0});
    check("reset_outs3", {in_ready3, sa_en3, busy3, done3, a_out3, b_out3}, {4'b1000, 48'b0});
    rst_n = 1'b1;

    sidx = 0;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      check($sformatf("vec%0d", r), {in_ready, sa_en, busy, done, a_out, b_out},
            {tbl[r].rdy, tbl[r].en, tbl[r].bsy, tbl[r].dn, tbl[r].ea, tbl[r].eb});
      if (tbl[r].en && sidx < S) begin
        ha[sidx] = a_out;
        hb[sidx] = b_out;
        sidx++;
      end
      in_valid = tbl[r].vld;
      a_col    = tbl[r].a;
      b_row    = tbl[r].b;
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("vec_acc_%0d%0d", i, j), 64'(acc_of(i, j)), 64'(exp_c[i][j]));

    // N=3, K=1 single-beat outer product
    @(negedge clk);
    in_valid3 = 1'b1;
    a_col3 = {8'd3, 8'd2, 8'd1};
    b_row3 = {8'd6, 8'd5, 8'd4};
    for (int t = 0; t < S3; t++) begin
      @(negedge clk);
      for (int i = 0; i < N3; i++) begin
        e3a[i] = (t == i) ? W'(i + 1) : '0;
        e3b[i] = (t == i) ? W'(i + 4) : '0;
      end
      check($sformatf("n3_stream_t%0d", t), {in_ready3, sa_en3, a_out3, b_out3}, {2'b01, e3a, e3b});
      h3a[t] = a_out3;
      h3b[t] = b_out3;
    end
    @(negedge clk);
    check("n3_done", {done3, sa_en3, a_out3, b_out3}, {2'b10, 48'b0});
    in_valid3 = 1'b0;
    for (int i = 0; i < N3; i++)
      for (int j = 0; j < N3; j++) begin
        acc = 0;
        for (int t = 0; t < S3; t++)
          if (t - j >= 0 && t - i >= 0)
            acc = acc + $signed(h3a[t-j][i]) * $signed(h3b[t-i][j]);
        check($sformatf("n3_acc_%0d%0d", i, j), 64'(acc), 64'((i + 1) * (j + 4)));
      end

    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    run_set(2, -1, 1'b0, 1'b0);

    set_ab(-128, -128, -128, -128, -128, -128, -128, -128);
    run_set(0, -1, 1'b0, 1'b0);

    set_rand();
    run_set(0, 1, 1'b0, 1'b0);
    set_rand();
    run_set(0, -1, 1'b0, 1'b0);

    set_rand();
    run_set(0, -1, 1'b1, 1'b0);
    set_rand();
    run_set(0, -1, 1'b0, 1'b1);

    for (int n = 0; n < 6; n++) begin
      set_rand();
      run_set(1, -1, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
